// File: rtl/aud_out_ser_pkg.sv
// Shared constants, serializer state encoding and the round/saturate helper
// for the audio output serializer.
package aud_out_ser_pkg;
    localparam int AUD_ACC_W      = 40;
    localparam int AUD_SMP_W      = 16;
    localparam int OUT_FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W     = 2;
    localparam int FIFO_LVL_W     = 3;

    localparam logic [AUD_SMP_W-1:0] SMP_MAX = 16'h7FFF;
    localparam logic [AUD_SMP_W-1:0] SMP_MIN = 16'h8000;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_RUN  = 1'b1
    } ser_state_e;

    typedef struct packed {
        logic [AUD_SMP_W-1:0] smp;
        logic                 clamped;
    } round_res_t;

    // Round-half-up then arithmetic shift at one bit wider than the accumulator,
    // so the rounding bias can never overflow.
    function automatic round_res_t round_sat(input logic signed [AUD_ACC_W-1:0] acc,
                                             input logic [3:0]                  shift);
        logic        [AUD_ACC_W:0] bias;
        logic signed [AUD_ACC_W:0] sum;
        logic signed [AUD_ACC_W:0] shifted;
        round_res_t                res;
        bias    = ({{AUD_ACC_W{1'b0}}, 1'b1} << shift) >> 1;
        sum     = $signed({acc[AUD_ACC_W-1], acc}) + $signed(bias);
        shifted = sum >>> shift;
        if (shifted > 41'sd32767) begin
            res.smp     = SMP_MAX;
            res.clamped = 1'b1;
        end else if (shifted < -41'sd32768) begin
            res.smp     = SMP_MIN;
            res.clamped = 1'b1;
        end else begin
            res.smp     = shifted[AUD_SMP_W-1:0];
            res.clamped = 1'b0;
        end
        return res;
    endfunction
endpackage

// File: rtl/aud_out_fifo.sv
// Four-entry sample FIFO; the head word is always presented so the serializer
// can load it in the same cycle it pops.
module aud_out_fifo
    import aud_out_ser_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  push_i,
    input  logic [AUD_SMP_W-1:0]  wdata_i,
    input  logic                  pop_i,
    output logic [AUD_SMP_W-1:0]  head_o,
    output logic [FIFO_LVL_W-1:0] level_o,
    output logic                  full_o,
    output logic                  empty_o
);
    logic [AUD_SMP_W-1:0]  mem_q [OUT_FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] wr_ptr_q;
    logic [FIFO_PTR_W-1:0] rd_ptr_q;
    logic [FIFO_LVL_W-1:0] level_q;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (level_q == FIFO_LVL_W'(OUT_FIFO_DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Storage is not reset: emptying the pointers is enough to discard it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + FIFO_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + FIFO_LVL_W'(1);
                2'b01:   level_q <= level_q - FIFO_LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end
endmodule

// File: rtl/aud_out_ser.sv
// Filter-result rounding/saturation into a sample FIFO, drained by an
// I2S-style serializer (MSB first, 16 bits per lrclk phase).
module aud_out_ser
    import aud_out_ser_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  filter_aud_out_rts,
    output logic                  filter_aud_out_rtr,
    input  logic [AUD_ACC_W-1:0]  filter_aud_out,
    input  logic [3:0]            rf_out_shift,
    input  logic [3:0]            rf_bclk_div,
    input  logic                  rf_ser_en,
    output logic                  ser_bclk,
    output logic                  ser_lrclk,
    output logic                  ser_sdata,
    output logic [FIFO_LVL_W-1:0] fifo_level,
    output logic                  sat_flag,
    output logic                  underrun
);
    logic                 xfer;
    round_res_t           rnd;
    logic                 sat_q;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [AUD_SMP_W-1:0] fifo_head;
    logic [AUD_SMP_W-1:0] next_word;

    ser_state_e           state_q, state_d;
    logic [3:0]           div_cnt_q, div_cnt_d;
    logic [3:0]           div_q, div_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [AUD_SMP_W-1:0] shreg_q, shreg_d;
    logic                 bclk_q, bclk_d;
    logic                 lrclk_q, lrclk_d;
    logic                 und_q, und_d;
    logic                 tick;
    logic                 fall;
    logic                 load_frame;

    assign filter_aud_out_rtr = ~fifo_full;
    assign xfer               = filter_aud_out_rts & filter_aud_out_rtr & rstb;
    assign rnd                = round_sat(filter_aud_out, rf_out_shift);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= xfer & rnd.clamped;
        end
    end

    aud_out_fifo u_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .push_i  (xfer),
        .wdata_i (rnd.smp),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // An empty FIFO at a frame boundary sends silence instead of stalling framing.
    assign next_word = fifo_empty ? '0 : fifo_head;
    assign tick      = (div_cnt_q == div_q);
    assign fall      = tick & bclk_q;

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q   <= SER_IDLE;
            div_cnt_q <= '0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            bclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            und_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            div_q     <= div_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            bclk_q    <= bclk_d;
            lrclk_q   <= lrclk_d;
            und_q     <= und_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SER_IDLE: if (rf_ser_en)  state_d = SER_RUN;
            SER_RUN:  if (!rf_ser_en) state_d = SER_IDLE;
            default:                  state_d = SER_IDLE;
        endcase
    end

    always_comb begin
        div_cnt_d  = div_cnt_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        bclk_d     = bclk_q;
        lrclk_d    = lrclk_q;
        und_d      = 1'b0;
        load_frame = 1'b0;
        if (state_d == SER_IDLE) begin
            div_cnt_d = '0;
            div_d     = '0;
            bit_cnt_d = '0;
            shreg_d   = '0;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b0;
        end else if (state_q == SER_IDLE) begin
            div_cnt_d  = '0;
            div_d      = rf_bclk_div;
            bit_cnt_d  = '0;
            bclk_d     = 1'b0;
            lrclk_d    = 1'b0;
            load_frame = 1'b1;
        end else if (tick) begin
            // Divider reload happens only here, so a new rate starts at a wrap.
            div_cnt_d = '0;
            div_d     = rf_bclk_div;
            bclk_d    = ~bclk_q;
            if (fall) begin
                if (bit_cnt_q == 4'd15) begin
                    bit_cnt_d  = '0;
                    lrclk_d    = ~lrclk_q;
                    load_frame = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    shreg_d   = {shreg_q[AUD_SMP_W-2:0], 1'b0};
                end
            end
        end else begin
            div_cnt_d = div_cnt_q + 4'd1;
        end
        if (load_frame) begin
            shreg_d = next_word;
            und_d   = fifo_empty;
        end
    end

    assign fifo_pop  = load_frame & ~fifo_empty;
    assign ser_bclk  = bclk_q;
    assign ser_lrclk = lrclk_q;
    assign ser_sdata = shreg_q[AUD_SMP_W-1];
    assign sat_flag  = sat_q;
    assign underrun  = und_q;
endmodule

// File: tb/tb_aud_out_ser.sv
// Self-checking bench: a queue/arithmetic model of the sample path and the
// serial timeline, checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_aud_out_ser;
    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        rts = 1'b0;
    logic        rtr;
    logic [39:0] acc = '0;
    logic [3:0]  shift = '0;
    logic [3:0]  div = '0;
    logic        en = 1'b0;
    logic        bclk, lrclk, sdata, sat, und;
    logic [2:0]  level;

    always #5 clk = ~clk;

    aud_out_ser dut (
        .clk                (clk),
        .rstb               (rstb),
        .filter_aud_out_rts (rts),
        .filter_aud_out_rtr (rtr),
        .filter_aud_out     (acc),
        .rf_out_shift       (shift),
        .rf_bclk_div        (div),
        .rf_ser_en          (en),
        .ser_bclk           (bclk),
        .ser_lrclk          (lrclk),
        .ser_sdata          (sdata),
        .fifo_level         (level),
        .sat_flag           (sat),
        .underrun           (und)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {clamped, sample} from plain integer arithmetic
    function automatic logic [16:0] ref_round(input logic [39:0] a, input int sh);
        longint v;
        v = longint'($signed(a));
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        if (v > 32767)  return {1'b1, 16'h7FFF};
        if (v < -32768) return {1'b1, 16'h8000};
        return {1'b0, v[15:0]};
    endfunction

    // ---------------- behavioural model ----------------
    logic [15:0] mq[$];
    bit          m_run = 0;
    int          m_k = 0;
    int          m_half = 1;
    logic [15:0] m_word = '0;
    bit          m_sat = 0;
    bit          m_und = 0;
    bit          chk_on = 0;

    task automatic start_frame();
        if (mq.size() > 0) m_word = mq.pop_front();
        else begin
            m_word = '0;
            m_und  = 1;
        end
    endtask

    initial forever begin : model
        bit          do_x;
        logic [16:0] r;
        @(posedge clk);
        if (!rstb) begin
            mq.delete();
            m_run = 0; m_k = 0; m_sat = 0; m_und = 0; m_word = '0;
        end else begin
            do_x  = rts && (mq.size() != 4);
            r     = ref_round(acc, int'(shift));
            m_und = 0;
            if (!m_run) begin
                if (en) begin
                    m_run = 1; m_k = 0; m_half = int'(div) + 1;
                    start_frame();
                end
            end else if (!en) begin
                m_run = 0;
            end else begin
                m_k++;
                if (m_k % (32 * m_half) == 0) start_frame();
            end
            if (do_x) mq.push_back(r[15:0]);
            m_sat = do_x && r[16];
        end
    end

    initial forever begin : compare
        @(negedge clk);
        if (chk_on) begin
            int   b;
            logic e_b, e_l, e_d;
            e_b = 1'b0; e_l = 1'b0; e_d = 1'b0;
            if (m_run) begin
                b   = (m_k / (2 * m_half)) % 16;
                e_b = ((m_k / m_half) % 2) == 1;
                e_l = ((m_k / (32 * m_half)) % 2) == 1;
                e_d = m_word[15 - b];
            end
            chk("rtr",      rtr,   mq.size() != 4);
            chk("level",    level, mq.size());
            chk("bclk",     bclk,  e_b);
            chk("lrclk",    lrclk, e_l);
            chk("sdata",    sdata, e_d);
            chk("sat_flag", sat,   m_sat);
            chk("underrun", und,   m_und);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_word(input logic [39:0] v, input logic [3:0] sh);
        acc = v; shift = sh; rts = 1'b1;
        @(negedge clk);
        rts = 1'b0;
    endtask

    // Assumes the next negedge is the first cycle of a frame at div=0.
    task automatic capture(output logic [15:0] w, output logic lr, output int bad);
        bad = 0; w = '0; lr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == 0) lr = lrclk;
            else if (lrclk !== lr) bad++;
            if (bclk !== (i % 2 == 1)) bad++;
            if (i % 2 == 0) w[15 - i / 2] = sdata;
        end
    endtask

    logic [15:0] cw;
    logic        clr;
    int          cbad;
    int          wv;
    bit          ok;
    int          cnt_und, cnt_one, used;
    logic [15:0] exp_words [4];
    logic [31:0] r1, r2;

    initial begin
        // model pins
        chk("mdl_rnd_24",   ref_round(40'd24, 4),      17'h00002);
        chk("mdl_rnd_m24",  ref_round(-40'sd24, 4),    17'h0FFFF);
        chk("mdl_rnd_8",    ref_round(40'd8, 4),       17'h00001);
        chk("mdl_rnd_5",    ref_round(40'd5, 0),       17'h00005);
        chk("mdl_sat_pos",  ref_round(40'd40000, 0),   17'h17FFF);
        chk("mdl_sat_neg",  ref_round(-40'sd40000, 0), 17'h18000);
        chk("mdl_nosat",    ref_round(40'd32767, 0),   17'h07FFF);

        // reset with a pending transfer
        rts = 1'b1; acc = 40'd7; rstb = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rtr", rtr, 1); chk("rst_level", level, 0);
        chk("rst_bclk", bclk, 0); chk("rst_lrclk", lrclk, 0); chk("rst_sdata", sdata, 0);
        chk("rst_sat", sat, 0); chk("rst_und", und, 0);
        rts = 1'b0; rstb = 1'b1; chk_on = 1;
        @(negedge clk);

        // rounding, serialized back out
        push_word(40'd24, 4'd4); push_word(-40'sd24, 4'd4);
        push_word(40'd8, 4'd4);  push_word(40'd5, 4'd0);
        chk("round_level", level, 4);
        exp_words[0] = 16'h0002; exp_words[1] = 16'hFFFF;
        exp_words[2] = 16'h0001; exp_words[3] = 16'h0005;
        en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            capture(cw, clr, cbad);
            chk("round_word", cw, exp_words[f]);
            chk("round_lr", clr, f % 2);
            chk("round_clk", cbad, 0);
        end
        en = 1'b0; repeat (2) @(negedge clk);

        // saturation
        push_word(40'd40000, 4'd0);   chk("sat_pos_flag", sat, 1);
        push_word(-40'sd40000, 4'd0); chk("sat_neg_flag", sat, 1);
        push_word(40'd32767, 4'd0);   chk("nosat_flag", sat, 0);
        exp_words[0] = 16'h7FFF; exp_words[1] = 16'h8000; exp_words[2] = 16'h7FFF;
        en = 1'b1;
        for (int f = 0; f < 3; f++) begin
            capture(cw, clr, cbad);
            chk("sat_word", cw, exp_words[f]);
        end
        en = 1'b0; repeat (2) @(negedge clk);

        // serial framing at div=0
        push_word(40'hFF_FFFF_A5C3, 4'd0); push_word(40'h00_0000_1234, 4'd0);
        en = 1'b1;
        capture(cw, clr, cbad);
        chk("ser_word0", cw, 16'hA5C3); chk("ser_lr0", clr, 0); chk("ser_clk0", cbad, 0);
        capture(cw, clr, cbad);
        chk("ser_word1", cw, 16'h1234); chk("ser_lr1", clr, 1); chk("ser_clk1", cbad, 0);
        en = 1'b0; repeat (2) @(negedge clk);

        // full FIFO back-pressure
        rts = 1'b1; wv = 1; acc = 40'd1; shift = 4'd0;
        repeat (8) begin
            ok = rtr;
            @(negedge clk);
            if (ok && wv < 5) begin wv++; acc = 40'(wv); end
        end
        chk("full_level", level, 4); chk("full_rtr", rtr, 0);
        en = 1'b1; ok = 0; used = 0;
        while (!ok && used < 4) begin
            @(negedge clk); used++;
            ok = (rtr === 1'b1);
        end
        chk("full_rtr_rises", ok, 1);
        @(negedge clk); used++;
        rts = 1'b0;
        chk("full_refill", level, 4);
        repeat (32 - used) @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            capture(cw, clr, cbad);
            chk("full_order", cw, 16'(f + 2));
        end
        en = 1'b0; repeat (2) @(negedge clk);

        // underrun with an empty FIFO, then reset mid-frame
        en = 1'b1; cnt_und = 0; cnt_one = 0;
        for (int i = 0; i < 96; i++) begin
            @(negedge clk);
            if (und === 1'b1) cnt_und++;
            if (sdata !== 1'b0) cnt_one++;
        end
        chk("und_pulses", cnt_und, 3); chk("und_silent", cnt_one, 0);
        push_word(-40'sd1, 4'd0);
        repeat (46) @(negedge clk);
        chk("mid_sdata_pre", sdata, 1);
        rstb = 1'b0; rts = 1'b1; acc = 40'd5;
        @(negedge clk);
        chk("mid_rst_bclk", bclk, 0); chk("mid_rst_lrclk", lrclk, 0);
        chk("mid_rst_sdata", sdata, 0); chk("mid_rst_level", level, 0);
        chk("mid_rst_rtr", rtr, 1); chk("mid_rst_und", und, 0);
        rstb = 1'b1; rts = 1'b0; en = 1'b0;
        @(negedge clk);

        // randomized traffic
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
            r1 = $urandom; r2 = $urandom;
            rts = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) acc = {{20{r1[19]}}, r1[19:0]};
            else acc = {r2[7:0], r1};
            shift = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) en = ~en;
            if (!en && $urandom_range(0, 3) == 0) div = 4'($urandom_range(0, 3));
            rstb = ($urandom_range(0, 799) != 0);
        end
        rstb = 1'b1; rts = 1'b0; en = 1'b0;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
